// File: rtl/ram8_pkg.sv
// Shared types and constants for the RAM8 arbiter slice.
// Requester ids double as the round-robin "last grant" encoding.
package ram8_pkg;

  localparam int RAM8_DEPTH  = 8;
  localparam int RAM8_ADDR_W = 3;
  localparam int RAM8_DATA_W = 16;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_IDLE,
    ST_ACCESS,
    ST_DONE
  } state_t;

endpackage

// File: rtl/ram8_arbiter_rr_arb2.sv
// Combinational two-input round-robin picker: a lone requester wins, a tie goes to
// whoever was not granted last. Zero latency; no backpressure of its own.
module rr_arb2
  import ram8_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       last_i,
  output logic       grant_o
);

  always_comb begin
    grant_o = REQ_A;
    case (req_i)
      2'b01:   grant_o = REQ_A;
      2'b10:   grant_o = REQ_B;
      2'b11:   grant_o = ~last_i;
      default: grant_o = REQ_A;
    endcase
  end

endmodule

// File: rtl/ram8_arbiter.sv
// Clears RAM8 after reset, then serves one A/B access at a time (ack 2 cycles after
// the sampling edge, 3-cycle minimum period); requesters hold req+command until ack.
module ram8_arbiter
  import ram8_pkg::*;
#(
  parameter int                    DATA_WIDTH = RAM8_DATA_W,
  parameter int                    ADDR_WIDTH = RAM8_ADDR_W,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [DATA_WIDTH-1:0] a_wdata,
  output logic                  a_ack,
  output logic [DATA_WIDTH-1:0] a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [DATA_WIDTH-1:0] b_wdata,
  output logic                  b_ack,
  output logic [DATA_WIDTH-1:0] b_rdata,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_in,
  output logic                  ram_load,
  input  logic [DATA_WIDTH-1:0] ram_out
);

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q;
  logic                  last_q;
  logic                  owner_q;
  logic                  cmd_we_q;
  logic [ADDR_WIDTH-1:0] cmd_addr_q;
  logic [DATA_WIDTH-1:0] cmd_wdata_q;
  logic                  a_ack_q, b_ack_q;
  logic [DATA_WIDTH-1:0] a_rdata_q, b_rdata_q;
  logic                  grant;
  logic                  any_req;

  assign any_req = a_req | b_req;

  rr_arb2 u_arb (
    .req_i   ({b_req, a_req}),
    .last_i  (last_q),
    .grant_o (grant)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_INIT;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT:   if (clr_addr_q == '1) state_d = ST_IDLE;
      ST_IDLE:   if (any_req) state_d = ST_ACCESS;
      ST_ACCESS: state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_INIT;
    endcase
  end

  always_comb begin
    busy        = 1'b0;
    ram_load    = 1'b0;
    ram_address = cmd_addr_q;
    ram_in      = cmd_wdata_q;
    case (state_q)
      ST_INIT: begin
        busy        = 1'b1;
        ram_load    = 1'b1;
        ram_address = clr_addr_q;
        ram_in      = INIT_VALUE;
      end
      ST_ACCESS: ram_load = cmd_we_q;
      default: ;
    endcase
  end

  // Command is latched at grant so requesters' later input changes cannot corrupt the access.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clr_addr_q  <= '0;
      last_q      <= REQ_B;
      owner_q     <= REQ_A;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      a_ack_q     <= 1'b0;
      b_ack_q     <= 1'b0;
      a_rdata_q   <= '0;
      b_rdata_q   <= '0;
    end else begin
      a_ack_q <= 1'b0;
      b_ack_q <= 1'b0;
      case (state_q)
        ST_INIT: clr_addr_q <= clr_addr_q + 1'b1;
        ST_IDLE: begin
          if (any_req) begin
            owner_q     <= grant;
            last_q      <= grant;
            cmd_we_q    <= (grant == REQ_B) ? b_we    : a_we;
            cmd_addr_q  <= (grant == REQ_B) ? b_addr  : a_addr;
            cmd_wdata_q <= (grant == REQ_B) ? b_wdata : a_wdata;
          end
        end
        ST_ACCESS: begin
          if (owner_q == REQ_A) a_ack_q <= 1'b1;
          else                  b_ack_q <= 1'b1;
          if (!cmd_we_q) begin
            if (owner_q == REQ_A) a_rdata_q <= ram_out;
            else                  b_rdata_q <= ram_out;
          end
        end
        default: ;
      endcase
    end
  end

  assign a_ack   = a_ack_q;
  assign b_ack   = b_ack_q;
  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;

endmodule

// File: tb/tb_ram8_arbiter.sv
// Bench for ram8_arbiter: RAM8 model plus a cycle-level reference of the arbitration rules.
module tb_ram8_arbiter;

  typedef struct {
    logic        we;
    logic [2:0]  addr;
    logic [15:0] wdata;
    int          start;
  } cmd_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        a_req, a_we, b_req, b_we;
  logic [2:0]  a_addr, b_addr;
  logic [15:0] a_wdata, b_wdata, a_rdata, b_rdata;
  logic        a_ack, b_ack, busy, ram_load;
  logic [2:0]  ram_address;
  logic [15:0] ram_in, ram_out;
  logic        preload = 1'b0;
  logic [15:0] mem [8];

  int          total = 0, bad = 0;
  int          cyc, free_at, pred_ack;
  bit          pend, last_b, win_b;
  logic [15:0] mm [8];
  logic [15:0] exp_rd_a, exp_rd_b;
  cmd_t        qa[$], qb[$];
  bit          order[$];
  int          ack_cyc[$];
  int          sa, sb;

  ram8_arbiter dut (
    .clk(clk), .reset(reset),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(b_ack), .b_rdata(b_rdata),
    .busy(busy), .ram_address(ram_address), .ram_in(ram_in), .ram_load(ram_load), .ram_out(ram_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (preload) for (int i = 0; i < 8; i++) mem[i] <= 16'hFFFF;
    else if (ram_load) mem[ram_address] <= ram_in;
  end
  assign ram_out = mem[ram_address];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic cmd_t mk(input logic we, input logic [2:0] addr, input logic [15:0] wdata, input int start);
    cmd_t c;
    c.we = we; c.addr = addr; c.wdata = wdata; c.start = start;
    return c;
  endfunction

  task automatic do_reset(input bit pre);
    reset = 1'b1; preload = pre;
    a_req = 1'b0; b_req = 1'b0;
    qa.delete(); qb.delete();
    @(negedge clk);
    check("rst_busy", busy, 1);
    check("rst_a_ack", a_ack, 0);
    check("rst_b_ack", b_ack, 0);
    check("rst_a_rdata", a_rdata, 0);
    check("rst_b_rdata", b_rdata, 0);
    check("rst_load", ram_load, 1);
    check("rst_addr", ram_address, 0);
    check("rst_in", ram_in, 0);
    @(negedge clk);
    preload = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    cyc = 0; free_at = 8; pend = 1'b0; last_b = 1'b1;
    for (int i = 0; i < 8; i++) mm[i] = 16'h0000;
    exp_rd_a = 16'h0000; exp_rd_b = 16'h0000;
  endtask

  // One loop iteration per cycle, at the negedge: check outputs, then drive and predict.
  task automatic run(input int min_cyc, input int max_cyc, input bit abort_access);
    int   n;
    bit   ea, eb;
    cmd_t c;
    n = 0;
    while (1) begin
      if (abort_access && pend && cyc == pred_ack - 1) return;
      if (n >= min_cyc && !pend && qa.size() == 0 && qb.size() == 0) return;
      if (n >= max_cyc) begin
        check("timeout", qa.size() + qb.size() + int'(pend), 0);
        return;
      end
      ea = pend && (pred_ack == cyc) && !win_b;
      eb = pend && (pred_ack == cyc) && win_b;
      check("busy", busy, cyc < 8);
      if (cyc < 8) begin
        check("clr_load", ram_load, 1);
        check("clr_addr", ram_address, cyc % 8);
        check("clr_in", ram_in, 0);
      end
      if (cyc == 8) for (int i = 0; i < 8; i++) check("clr_mem", mem[i], 0);
      check("a_ack", a_ack, ea);
      check("b_ack", b_ack, eb);
      if (a_ack === 1'b1) begin order.push_back(1'b0); ack_cyc.push_back(cyc); end
      if (b_ack === 1'b1) begin order.push_back(1'b1); ack_cyc.push_back(cyc); end
      if (ea) begin check("a_rdata", a_rdata, exp_rd_a); void'(qa.pop_front()); end
      if (eb) begin check("b_rdata", b_rdata, exp_rd_b); void'(qb.pop_front()); end
      if (ea || eb) begin pend = 1'b0; free_at = cyc + 1; end

      if (!ea && qa.size() > 0 && qa[0].start <= cyc) begin
        a_req = 1'b1; a_we = qa[0].we; a_addr = qa[0].addr; a_wdata = qa[0].wdata;
      end else begin
        a_req = 1'b0; a_we = 1'($urandom); a_addr = 3'($urandom); a_wdata = 16'($urandom);
      end
      if (!eb && qb.size() > 0 && qb[0].start <= cyc) begin
        b_req = 1'b1; b_we = qb[0].we; b_addr = qb[0].addr; b_wdata = qb[0].wdata;
      end else begin
        b_req = 1'b0; b_we = 1'($urandom); b_addr = 3'($urandom); b_wdata = 16'($urandom);
      end

      if (!pend && cyc >= free_at && (a_req || b_req)) begin
        win_b    = (a_req && b_req) ? !last_b : b_req;
        last_b   = win_b;
        pend     = 1'b1;
        pred_ack = cyc + 2;
        c = win_b ? qb[0] : qa[0];
        if (c.we) mm[c.addr] = c.wdata;
        else if (win_b) exp_rd_b = mm[c.addr];
        else exp_rd_a = mm[c.addr];
      end
      @(negedge clk);
      cyc++; n++;
    end
  endtask

  initial begin
    int t0, nb;
    a_req = 1'b0; b_req = 1'b0; a_we = 1'b0; b_we = 1'b0;
    a_addr = '0; b_addr = '0; a_wdata = '0; b_wdata = '0;

    // Clear after reset over a RAM full of 0xFFFF
    do_reset(1'b1);
    run(12, 40, 1'b0);

    // Single write then read by A
    order.delete(); ack_cyc.delete();
    t0 = cyc;
    qa.push_back(mk(1'b1, 3'd5, 16'h1234, cyc));
    qa.push_back(mk(1'b0, 3'd5, 16'h0000, cyc));
    run(0, 40, 1'b0);
    check("wr_rd_data", a_rdata, 16'h1234);
    check("wr_rd_acks", order.size(), 2);
    nb = 0;
    foreach (order[k]) nb += int'(order[k]);
    check("wr_rd_no_b", nb, 0);
    check("wr_lat", ack_cyc[0] - t0, 2);
    check("rd_lat", ack_cyc[1] - t0, 5);

    // Tie right after reset: A first, B three cycles later
    do_reset(1'b0);
    order.delete(); ack_cyc.delete();
    qa.push_back(mk(1'b0, 3'd0, 16'h0000, 8));
    qb.push_back(mk(1'b0, 3'd0, 16'h0000, 8));
    run(0, 40, 1'b0);
    check("tie_first", order[0], 0);
    check("tie_second", order[1], 1);
    check("tie_a_cyc", ack_cyc[0], 10);
    check("tie_b_cyc", ack_cyc[1], 13);
    check("tie_a_rd", a_rdata, 0);
    check("tie_b_rd", b_rdata, 0);

    // Sustained contention: strict alternation starting with A (B won last)
    order.delete(); ack_cyc.delete();
    for (int i = 0; i < 4; i++) begin
      qa.push_back(mk(1'b1, 3'(i), 16'hA000 + 16'(i), cyc));
      qb.push_back(mk(1'b1, 3'(i + 4), 16'hB000 + 16'(i), cyc));
    end
    run(0, 100, 1'b0);
    check("cont_count", order.size(), 8);
    for (int k = 0; k < 8; k++) check("cont_order", order[k], k % 2);
    for (int i = 0; i < 8; i++)
      check("cont_mem", mem[i], (i < 4) ? 16'hA000 + i : 16'hB000 + i - 4);

    // Request raised during clear cycle 3 waits for IDLE
    do_reset(1'b0);
    ack_cyc.delete();
    qb.push_back(mk(1'b0, 3'd3, 16'h0000, 3));
    run(0, 40, 1'b0);
    check("init_req_cyc", ack_cyc[0], 10);
    check("init_req_rd", b_rdata, 0);

    // Random mixed traffic
    sa = cyc; sb = cyc;
    for (int k = 0; k < 24; k++) begin
      sa += $urandom_range(0, 5);
      sb += $urandom_range(0, 5);
      qa.push_back(mk(1'($urandom), 3'($urandom), 16'($urandom), sa));
      qb.push_back(mk(1'($urandom), 3'($urandom), 16'($urandom), sb));
    end
    run(0, 3000, 1'b0);

    // Reset during the ACCESS cycle of a write: no ack, write lost, clear restarts
    qa.push_back(mk(1'b1, 3'd2, 16'h5555, cyc));
    run(0, 40, 1'b1);
    do_reset(1'b0);
    qa.push_back(mk(1'b0, 3'd2, 16'h0000, 8));
    run(0, 40, 1'b0);
    check("abort_rd", a_rdata, 0);
    check("abort_mem", mem[2], 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram8_arbiter.md
# ram8_arbiter

Two-port, round-robin arbiter and sequencer for one RAM8 (8 × 16-bit register file, combinational read, write on rising edge when load is high). It clears the RAM after reset, then serves one access at a time from two requesters (A, B) over a req/ack handshake. It drives the RAM8 `address`/`in`/`load` pins and consumes its `out`. It sits between the CPU-side and debug/loader-side masters and the RAM8 instance.

## Interface
Parameters:
- DATA_WIDTH, 16, word width; must match RAM8.
- ADDR_WIDTH, 3, address width; depth is 2^ADDR_WIDTH = 8.
- INIT_VALUE, 0, word written to every location during the post-reset clear.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- a_req  in  1  requester A asks for one access; held with its command until a_ack.
- a_we  in  1  1 = write, 0 = read.
- a_addr  in  ADDR_WIDTH  target address.
- a_wdata  in  DATA_WIDTH  write data.
- a_ack  out  1  one-cycle completion pulse for A.
- a_rdata  out  DATA_WIDTH  read result for A; valid while a_ack is high.
- b_req, b_we, b_addr, b_wdata, b_ack, b_rdata: same as A, for requester B.
- busy  out  1  high while the post-reset clear is in progress.
- ram_address  out  ADDR_WIDTH  to RAM8 `address`.
- ram_in  out  DATA_WIDTH  to RAM8 `in`.
- ram_load  out  1  to RAM8 `load`.
- ram_out  in  DATA_WIDTH  from RAM8 `out`.

## Operation
- FSM states: INIT, IDLE, ACCESS, DONE.
- **INIT**
  - 3-bit counter `clr_addr` steps 0..7.
  - Drives ram_address=clr_addr, ram_in=INIT_VALUE, ram_load=1, busy=1.
  - Goes to IDLE after the edge that writes address 7.
  - Requests are ignored and stay pending.
- **IDLE**
  - If a_req or b_req is high, pick a winner on the edge.
  - Latch the winner's we, addr and wdata into command registers, update `last_grant`, go to ACCESS.
  - Drives ram_load=0.
- **Arbitration**
  - A single requester wins.
  - If both request, the winner is the requester that is not `last_grant`.
  - `last_grant` resets to B, so A wins the first tie.
- **ACCESS** (one cycle)
  - Drives ram_address, ram_in and ram_load from the latched command (ram_load = latched we).
  - On the ending edge: a read captures ram_out into the winner's rdata register; a write leaves rdata unchanged.
  - Then go to DONE.
- **DONE** (one cycle)
  - The winner's ack is high and ram_load=0.
  - The requester must drop req by the edge that ends DONE.
  - Then go to IDLE.
- **Outputs**
  - ram_* and busy are combinational decodes of state and registers.
  - ack and rdata are registered.
- **Reset values**
  - state=INIT, clr_addr=0, last_grant=B.
  - a_ack=b_ack=0, a_rdata=b_rdata=0, busy=1.
  - ram_load=1, ram_address=0, ram_in=INIT_VALUE. Writing INIT_VALUE to address 0 while reset is held is permitted.
- **Reset mid-operation**
  - Any in-flight access is abandoned with no ack.
  - The clear sequence restarts from address 0.
- The RAM8 itself has no reset; its contents are defined only by INIT.

## Timing
- Clear occupies exactly 8 cycles after reset deassertion. busy falls in the 9th cycle (the first IDLE cycle).
- Access latency from the edge that samples req in IDLE: ACCESS on cycle +1, ack/rdata on cycle +2. Minimum period is 3 cycles per access.
- Read-after-write to the same address by either requester returns the new data.
- Both req high with A just served: B is granted at the next IDLE.
- Under continuous contention, A and B alternate strictly.
- Only one of a_ack/b_ack is ever high in a cycle.
- req raised during DONE by the other requester is honoured at the following IDLE.

## Structure
- Shared package `ram8_pkg` holds:
  - state enum (INIT, IDLE, ACCESS, DONE);
  - constants RAM8_DEPTH=8, RAM8_ADDR_W=3, RAM8_DATA_W=16;
  - requester-id constants REQ_A=0, REQ_B=1.
- One natural sub-module: `rr_arb2`, a combinational two-input round-robin picker with inputs req[1:0] and last, output grant id. Everything else stays in `ram8_arbiter`.
- The RAM8 instance lives in the parent, not inside this block.

## Test plan
- **Reset/clear:** pre-load RAM with 0xFFFF, pulse reset → busy high 8 cycles, ram_load high with ram_address 0..7, then every location reads 0x0000.
- **Single write then read:** A writes 0x1234 to addr 5, then A reads addr 5 → a_ack after exactly 2 cycles each, a_rdata=0x1234, b_ack never high.
- **Tie after reset:** A and B both read addr 0 in the same cycle → A acked first, B acked 3 cycles later, both rdata=0x0000.
- **Sustained contention:** A writes addresses 0..3 with 0xA000+i while B writes 4..7 with 0xB000+i, both holding req → grants alternate A,B,A,B and final contents match.
- **Request during INIT:** B raises req in clear cycle 3 → no ack until after busy falls, then b_ack on IDLE+2.
- **Reset mid-access:** assert reset during ACCESS of an A write to addr 2 with 0x5555 → no a_ack, clear restarts, addr 2 reads 0x0000.
